fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
Read-side adapter placed directly downstream of the flop-based FIFO (fifo_ff). It drives the FIFO's rd_en, captures rd_data after a fixed read latency, and presents a registered valid/ready stream to the consumer. A small credit-managed prefetch buffer absorbs the FIFO read latency, so one word per cycle is sustained while m_ready stays high.

Parameters:
WIDTH, 8, data width; must equal the FIFO data width.
RD_LATENCY, 1, cycles from fifo_rd_en high to fifo_rd_data valid; legal values 1..3.
BUF_DEPTH, RD_LATENCY+2, prefetch entries; derived, not overridable.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
fifo_empty  in  1  FIFO empty flag.
fifo_rd_en  out  1  pop request to the FIFO.
fifo_rd_data  in  WIDTH  FIFO read data, valid RD_LATENCY cycles after fifo_rd_en.
m_valid  out  1  stream word valid.
m_ready  in  1  consumer accepts the word.
m_data  out  WIDTH  stream word (head of the prefetch buffer).
m_count  out  $clog2(BUF_DEPTH+1)  words currently held in the prefetch buffer.

Behaviour:
- Reset (async assert, sync deassert handled upstream): fifo_rd_en=0, m_valid=0, m_data=0, m_count=0, inflight shift register cleared, buffer pointers = 0.
- Issue: fifo_rd_en = !fifo_empty && (m_count + inflight_cnt) < BUF_DEPTH.
  - Uses registered state only; no combinational path from m_ready.
  - Never issues while rst=1.
- Inflight tracking: RD_LATENCY-bit shift register; bit0 = fifo_rd_en; bit[RD_LATENCY-1] = data arriving this cycle. inflight_cnt = popcount.
- Capture: when the arrival bit is 1, write fifo_rd_data into the buffer at wr_ptr at the clock edge.
- Output: m_valid = (m_count != 0), registered; m_data = buf[rd_ptr].
  - Pop on m_valid && m_ready.
  - m_data must hold stable while m_valid=1 && m_ready=0.
- Simultaneous capture and pop: m_count unchanged; both pointers advance.
- Pointers wrap modulo BUF_DEPTH; BUF_DEPTH need not be a power of 2 (explicit wrap compare).
- Overflow impossible by credit rule: assertion on capture when m_count==BUF_DEPTH.
- Latency: fifo_empty falls in cycle 0 with the buffer empty -> fifo_rd_en in cycle 0 -> m_valid=1 in cycle RD_LATENCY+1.
- Throughput: with m_ready=1 and the FIFO non-empty, fifo_rd_en=1 every cycle and one word per cycle out.
- Backpressure: with m_ready=0, issuing stops once m_count+inflight reaches BUF_DEPTH; exactly BUF_DEPTH words are held; none are lost or duplicated.
- Order: output order equals FIFO pop order.
- Reset mid-operation: in-flight reads are discarded and the buffer is cleared. The FIFO is reset in the same domain, so its contents are also gone; no stale word may appear after reset.
- fifo_empty rising while reads are in flight: no further issue; in-flight words still land and drain.

Decomposition:
- Shared package fifo_pkg: parameter legality check for RD_LATENCY, buffer-depth function, and the count width function clog2(BUF_DEPTH+1).
- One sub-module, fifo_rd_skid_buf: BUF_DEPTH-entry register ring with wr/rd pointers and count. The top level holds issue/credit logic and the inflight shift register.

Test Plan:
1. Reset, FIFO preloaded with 0x11..0x14, m_ready=1 -> fifo_rd_en high 4 consecutive cycles; m_data = 0x11,0x12,0x13,0x14 on consecutive cycles; first m_valid RD_LATENCY+1 cycles after first rd_en.
2. FIFO holds 10 words, m_ready=0 -> exactly BUF_DEPTH (3 for RD_LATENCY=1) pops; m_count=3; m_data=first word stable. Raise m_ready -> all 10 words delivered in order, no gaps after the first.
3. Random m_ready (50%), 200 words, random fifo write gaps -> scoreboard: in-order, no loss or duplication; m_count+inflight never exceeds BUF_DEPTH.
4. Single word written into the empty FIFO -> one rd_en pulse; m_valid for exactly one cycle with m_ready=1; fifo_rd_en stays 0 afterwards while fifo_empty=1.
5. Assert rst while 2 reads are in flight and m_count=2 -> m_valid=0 and m_count=0 immediately (async); after release, no output until new FIFO writes; first new word 0x55 appears correctly.
6. RD_LATENCY=3 build, continuous m_ready=1 -> sustained 1 word/cycle; BUF_DEPTH=5 wrap exercised over 20 words.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO read-side stream adapter: latency legality,
// prefetch depth derivation and occupancy-counter width.
package fifo_pkg;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 3;

  // The adapter only supports the read latencies the FIFO can be built with.
  function automatic bit rd_latency_ok(input int rd_latency);
    return (rd_latency >= RD_LATENCY_MIN) && (rd_latency <= RD_LATENCY_MAX);
  endfunction

  // Enough entries to cover every word in flight plus one being consumed
  // and one landing, so a steady stream never starves.
  function automatic int buf_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

  // Counter must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small register ring that holds prefetched FIFO words until the consumer
// takes them. The depth need not be a power of two, so pointers wrap with
// an explicit compare against the last index.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_IDX) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign pop     = rd_en && valid;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this edge; a simultaneous write and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    if (wr_en && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !wr_en) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Ring storage, pointers, count and the registered valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_next;
      valid <= (count_next != '0);
    end
  end

  // The issuing side only requests words it has room for, so a landing word
  // can never find the ring full.
  assert property (@(posedge clk) disable iff (rst) !(wr_en && (count == FULL_CNT)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the flop-based FIFO: issues pops against a credit
// budget, tracks reads in flight across the FIFO read latency, and presents
// the landed words as a registered valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int RD_LATENCY = 1,
  localparam int BUF_DEPTH  = buf_depth(RD_LATENCY),
  localparam int CNT_W      = count_width(BUF_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] m_count
);

  localparam int SUM_W = CNT_W + 1;

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("fifo_rd_stream: RD_LATENCY must be in 1..3");
  end

  logic [RD_LATENCY-1:0] inflight;
  logic                  arrive;
  logic [SUM_W-1:0]      credit_used;

  // Words held plus words still coming back from the FIFO; issuing is
  // throttled on this so the buffer can always accept every arrival.
  // Only registered state feeds it, so m_ready never reaches fifo_rd_en.
  assign credit_used = SUM_W'(m_count) + SUM_W'($countones(inflight));
  assign fifo_rd_en  = !rst && !fifo_empty && (credit_used < SUM_W'(BUF_DEPTH));
  assign arrive      = inflight[RD_LATENCY-1];

  // Delay line of issued pops; the top bit marks the word arriving this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      inflight <= RD_LATENCY'({inflight, fifo_rd_en});
    end
  end

  fifo_rd_skid_buf #(
    .WIDTH(WIDTH),
    .DEPTH(BUF_DEPTH),
    .CNT_W(CNT_W)
  ) u_skid_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (arrive),
    .wr_data (fifo_rd_data),
    .rd_en   (m_ready),
    .rd_data (m_data),
    .valid   (m_valid),
    .count   (m_count)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream. Two instances run side by side
// (read latency 1 and 3), each fed by a queue-based FIFO model and checked
// against a scoreboard of written words in write order.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int    LAT   = (g == 0) ? 1 : 3;
    localparam int    DEPTH = LAT + 2;
    localparam int    CW    = $clog2(DEPTH + 1);
    localparam string LN    = (g == 0) ? "lat1_" : "lat3_";

    logic           fifo_empty;
    logic           fifo_rd_en;
    logic [7:0]     fifo_rd_data;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [7:0]     m_data;
    logic [CW-1:0]  m_count;

    logic [7:0]     wr_pending[$];
    logic [7:0]     fq[$];
    logic [7:0]     exp_q[$];
    logic [7:0]     pipe_d [LAT];
    logic [LAT-1:0] pipe_v;
    int landed = 0, accepted = 0;
    int cyc = 0;
    int rd_cnt, last_rd, rd_gaps, first_rd;
    int val_cnt, first_val, dlv_cnt, last_dlv, gaps;
    logic [7:0] last_word;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data;
    int credit;

    fifo_rd_stream #(
      .WIDTH(8),
      .RD_LATENCY(LAT)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_count      (m_count)
    );

    // FIFO model: pops feed a LAT-deep data pipe, writes land in bulk.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        fq.delete();
        wr_pending.delete();
        exp_q.delete();
        pipe_v <= '0;
        fifo_empty <= 1'b1;
        landed = 0;
        accepted = 0;
      end else begin
        if (pipe_v[LAT-1]) landed++;
        pipe_v <= LAT'({pipe_v, fifo_rd_en});
        if (fifo_rd_en && fq.size() != 0) pipe_d[0] <= fq.pop_front();
        else pipe_d[0] <= 8'($urandom);
        for (int k = 1; k < LAT; k++) pipe_d[k] <= pipe_d[k-1];
        while (wr_pending.size() != 0) fq.push_back(wr_pending.pop_front());
        fifo_empty <= (fq.size() == 0);
      end
    end

    assign fifo_rd_data = pipe_d[LAT-1];

    // Monitor on the falling edge: occupancy, credit, hold and scoreboard.
    always @(negedge clk) begin
      cyc++;
      if (rst) begin
        if (mon_en) begin
          checkOutput({LN, "rst_valid"}, m_valid, 0);
          checkOutput({LN, "rst_count"}, m_count, 0);
          checkOutput({LN, "rst_rd_en"}, fifo_rd_en, 0);
        end
        prev_hold = 1'b0;
      end else if (mon_en) begin
        credit = int'(m_count) + $countones(pipe_v);
        checkOutput({LN, "credit"}, credit <= DEPTH, 1);
        checkOutput({LN, "count"}, m_count, landed - accepted);
        checkOutput({LN, "valid"}, m_valid, (landed - accepted) != 0);
        if (prev_hold) checkOutput({LN, "hold_data"}, m_data, prev_data);
        if (fifo_rd_en) begin
          checkOutput({LN, "rd_nonempty"}, fifo_empty, 0);
          if (rd_cnt > 0 && cyc != last_rd + 1) rd_gaps++;
          if (first_rd < 0) first_rd = cyc;
          rd_cnt++;
          last_rd = cyc;
        end
        if (m_valid) begin
          val_cnt++;
          if (first_val < 0) first_val = cyc;
        end
        if (m_valid && m_ready) begin
          checkOutput({LN, "word_expected"}, exp_q.size() != 0, 1);
          if (exp_q.size() != 0) checkOutput({LN, "data"}, m_data, exp_q.pop_front());
          if (dlv_cnt > 0 && cyc != last_dlv + 1) gaps++;
          dlv_cnt++;
          last_dlv = cyc;
          last_word = m_data;
          accepted++;
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
      end
    end
  end

  // Drive both ready inputs and advance one cycle (inputs change 1 after the edge).
  task automatic applyStimulus(input logic rdy0, input logic rdy1);
    g_lane[0].m_ready = rdy0;
    g_lane[1].m_ready = rdy1;
    @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input int lane, input logic [7:0] w);
    if (lane == 0) begin
      g_lane[0].wr_pending.push_back(w);
      g_lane[0].exp_q.push_back(w);
    end else begin
      g_lane[1].wr_pending.push_back(w);
      g_lane[1].exp_q.push_back(w);
    end
  endtask

  task automatic segStart();
    g_lane[0].rd_cnt = 0;  g_lane[0].rd_gaps = 0;  g_lane[0].first_rd = -1;
    g_lane[0].val_cnt = 0; g_lane[0].first_val = -1;
    g_lane[0].dlv_cnt = 0; g_lane[0].gaps = 0;
    g_lane[1].rd_cnt = 0;  g_lane[1].rd_gaps = 0;  g_lane[1].first_rd = -1;
    g_lane[1].val_cnt = 0; g_lane[1].first_val = -1;
    g_lane[1].dlv_cnt = 0; g_lane[1].gaps = 0;
  endtask

  initial begin
    int wn0, wn1, guard;
    logic reached;

    segStart();
    #2 rst = 1'b1;
    mon_en = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0);

    // Preloaded burst on both lanes with the consumer always ready.
    segStart();
    for (int i = 0; i < 4; i++) pushWord(0, 8'(8'h11 + i));
    for (int i = 0; i < 20; i++) pushWord(1, 8'(8'hA0 + i));
    repeat (35) applyStimulus(1'b1, 1'b1);
    checkOutput("t1_rd_cnt", g_lane[0].rd_cnt, 4);
    checkOutput("t1_rd_gaps", g_lane[0].rd_gaps, 0);
    checkOutput("t1_latency", g_lane[0].first_val - g_lane[0].first_rd, 2);
    checkOutput("t1_dlv_cnt", g_lane[0].dlv_cnt, 4);
    checkOutput("t1_dlv_gaps", g_lane[0].gaps, 0);
    checkOutput("t6_rd_cnt", g_lane[1].rd_cnt, 20);
    checkOutput("t6_rd_gaps", g_lane[1].rd_gaps, 0);
    checkOutput("t6_latency", g_lane[1].first_val - g_lane[1].first_rd, 4);
    checkOutput("t6_dlv_cnt", g_lane[1].dlv_cnt, 20);
    checkOutput("t6_dlv_gaps", g_lane[1].gaps, 0);

    // Backpressure: ten words queued, consumer stalled.
    segStart();
    for (int i = 0; i < 10; i++) pushWord(0, 8'(8'h20 + i));
    repeat (15) applyStimulus(1'b0, 1'b0);
    checkOutput("t2_rd_cnt", g_lane[0].rd_cnt, 3);
    checkOutput("t2_count", g_lane[0].m_count, 3);
    checkOutput("t2_valid", g_lane[0].m_valid, 1);
    checkOutput("t2_head", g_lane[0].m_data, 8'h20);
    segStart();
    repeat (20) applyStimulus(1'b1, 1'b0);
    checkOutput("t2_dlv_cnt", g_lane[0].dlv_cnt, 10);
    checkOutput("t2_dlv_gaps", g_lane[0].gaps, 0);
    checkOutput("t2_rd_rest", g_lane[0].rd_cnt, 7);
    checkOutput("t2_left", g_lane[0].exp_q.size(), 0);

    // Random write gaps and random consumer readiness on both lanes.
    segStart();
    wn0 = 0; wn1 = 0; guard = 0;
    while ((wn0 < 200 || wn1 < 200) && guard < 2000) begin
      if (wn0 < 200 && $urandom_range(1, 0) == 1) begin pushWord(0, 8'($urandom)); wn0++; end
      if (wn1 < 200 && $urandom_range(1, 0) == 1) begin pushWord(1, 8'($urandom)); wn1++; end
      applyStimulus(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      guard++;
    end
    guard = 0;
    while ((g_lane[0].exp_q.size() != 0 || g_lane[1].exp_q.size() != 0) && guard < 300) begin
      applyStimulus(1'b1, 1'b1);
      guard++;
    end
    repeat (3) applyStimulus(1'b1, 1'b1);
    checkOutput("t3_left0", g_lane[0].exp_q.size(), 0);
    checkOutput("t3_left1", g_lane[1].exp_q.size(), 0);
    checkOutput("t3_dlv0", g_lane[0].dlv_cnt, 200);
    checkOutput("t3_dlv1", g_lane[1].dlv_cnt, 200);

    // A single word through an otherwise empty FIFO.
    segStart();
    pushWord(0, 8'h3C);
    repeat (10) applyStimulus(1'b1, 1'b1);
    checkOutput("t4_rd_cnt", g_lane[0].rd_cnt, 1);
    checkOutput("t4_val_cnt", g_lane[0].val_cnt, 1);
    checkOutput("t4_dlv_cnt", g_lane[0].dlv_cnt, 1);
    checkOutput("t4_word", g_lane[0].last_word, 8'h3C);

    // Reset with two words held and two in flight on the latency-3 lane.
    segStart();
    for (int i = 0; i < 4; i++) pushWord(1, 8'(8'h40 + i));
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (g_lane[1].m_count == 3'd2 && $countones(g_lane[1].pipe_v) == 2) reached = 1'b1;
    end
    checkOutput("t5_reach", reached, 1);
    rst = 1'b1;
    #1;
    checkOutput("t5_valid_async", g_lane[1].m_valid, 0);
    checkOutput("t5_count_async", g_lane[1].m_count, 0);
    checkOutput("t5_rd_en_async", g_lane[1].fifo_rd_en, 0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    segStart();
    repeat (6) applyStimulus(1'b1, 1'b1);
    checkOutput("t5_quiet_rd", g_lane[1].rd_cnt, 0);
    checkOutput("t5_quiet_val", g_lane[1].val_cnt, 0);
    pushWord(1, 8'h55);
    pushWord(0, 8'h55);
    repeat (10) applyStimulus(1'b1, 1'b1);
    checkOutput("t5_dlv1", g_lane[1].dlv_cnt, 1);
    checkOutput("t5_word1", g_lane[1].last_word, 8'h55);
    checkOutput("t5_dlv0", g_lane[0].dlv_cnt, 1);
    checkOutput("t5_word0", g_lane[0].last_word, 8'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
